mem_access_sequencer: RTL and testbench

Multi-cycle controller for the memory stage: takes the `DATA_CACHE_READ`/`DATA_CACHE_WRITE` controls produced by the instruction decoder and sequences one data-cache transaction per instruction over a valid/ready request and valid response interface. It stalls the pipeline while the access is outstanding. For loads it returns aligned, sign- or zero-extended data to write-back. Misaligned accesses, illegal encodings and timeouts are reported as faults.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/load_data_aligner.sv | 45 ++++
 rtl/mem_access_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the memory-stage access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Load encodings, shared with the instruction decoder
    localparam logic [2:0] c_RD_NONE = 3'b000;
    localparam logic [2:0] c_RD_LB   = 3'b001;
    localparam logic [2:0] c_RD_LH   = 3'b010;
    localparam logic [2:0] c_RD_LW   = 3'b011;
    localparam logic [2:0] c_RD_LBU  = 3'b100;
    localparam logic [2:0] c_RD_LHU  = 3'b101;

    // Store encodings
    localparam logic [1:0] c_WR_NONE = 2'b00;
    localparam logic [1:0] c_WR_SB   = 2'b01;
    localparam logic [1:0] c_WR_SH   = 2'b10;
    localparam logic [1:0] c_WR_SW   = 2'b11;

    // Fault causes
    localparam logic [1:0] c_FAULT_MISALIGNED = 2'b00;
    localparam logic [1:0] c_FAULT_ILLEGAL    = 2'b01;
    localparam logic [1:0] c_FAULT_TIMEOUT    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_legal_read(input logic [2:0] code);
        return (code <= c_RD_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_data_aligner.sv
`default_nettype none
// ============================================================================
// Module      : load_data_aligner
// Description : Selects the addressed byte/half-word of a read word and
//               sign- or zero-extends it according to the load type.
// Revision    : 1.0 - initial release
// ============================================================================
module load_data_aligner
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Half-word loads are already known to be 2-byte aligned here
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = 32'h0000_0000;
        case (i_load_type)
            c_RD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            c_RD_LH:  o_data = {{16{w_half[15]}}, w_half};
            c_RD_LW:  o_data = i_word;
            c_RD_LBU: o_data = {24'h000000, w_byte};
            c_RD_LHU: o_data = {16'h0000, w_half};
            default:  o_data = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_sequencer
// Description : Sequences one data-cache transaction per memory-stage
//               instruction, stalls the pipeline and reports faults.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_VALID,
    input  logic [2:0]  DATA_CACHE_READ,
    input  logic [1:0]  DATA_CACHE_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] STORE_DATA,
    input  logic [4:0]  RD_ADDRESS,
    output logic        STALL,
    output logic        CACHE_REQ_VALID,
    input  logic        CACHE_REQ_READY,
    output logic        CACHE_REQ_WRITE,
    output logic [31:0] CACHE_REQ_ADDRESS,
    output logic [3:0]  CACHE_REQ_BYTE_EN,
    output logic [31:0] CACHE_REQ_WDATA,
    input  logic        CACHE_RESP_VALID,
    input  logic [31:0] CACHE_RESP_RDATA,
    output logic        LOAD_VALID,
    output logic [31:0] LOAD_DATA,
    output logic [4:0]  LOAD_RD_ADDRESS,
    output logic        ACCESS_FAULT,
    output logic [1:0]  FAULT_CAUSE
);

    localparam int                 c_CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_VAL = c_CNT_W'(TIMEOUT_CYCLES);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_timeout_fire;

    logic               r_req_write;
    logic [31:0]        r_req_addr;
    logic [3:0]         r_byte_en;
    logic [31:0]        r_wdata;
    logic [1:0]         r_offset;
    logic [2:0]         r_load_type;
    logic [4:0]         r_rd_latched;
    logic [31:0]        r_load_data;
    logic [4:0]         r_load_rd;
    logic               r_load_done;
    logic               r_is_fault;
    logic [1:0]         r_fault_cause;

    logic               w_has_access;
    logic               w_illegal;
    logic               w_misaligned;
    logic               w_fault;
    logic [3:0]         w_byte_en;
    logic [31:0]        w_wdata;
    logic [31:0]        w_aligned;

    // Decode of the instruction presented in IDLE
    always_comb begin
        w_has_access = (DATA_CACHE_READ != c_RD_NONE) || (DATA_CACHE_WRITE != c_WR_NONE);
        w_illegal    = !is_legal_read(DATA_CACHE_READ) ||
                       ((DATA_CACHE_READ != c_RD_NONE) && (DATA_CACHE_WRITE != c_WR_NONE));
        w_misaligned = ((DATA_CACHE_READ == c_RD_LH || DATA_CACHE_READ == c_RD_LHU ||
                         DATA_CACHE_WRITE == c_WR_SH) && ADDRESS[0]) ||
                       ((DATA_CACHE_READ == c_RD_LW || DATA_CACHE_WRITE == c_WR_SW) &&
                        (ADDRESS[1:0] != 2'b00));
        w_fault      = w_illegal || w_misaligned;
    end

    always_comb begin
        w_byte_en = 4'b1111;
        w_wdata   = 32'h0000_0000;
        case (DATA_CACHE_WRITE)
            c_WR_SB: begin
                w_byte_en = 4'b0001 << ADDRESS[1:0];
                w_wdata   = {4{STORE_DATA[7:0]}};
            end
            c_WR_SH: begin
                w_byte_en = 4'b0011 << {ADDRESS[1], 1'b0};
                w_wdata   = {2{STORE_DATA[15:0]}};
            end
            c_WR_SW: begin
                w_byte_en = 4'b1111;
                w_wdata   = STORE_DATA;
            end
            default: begin
                w_byte_en = 4'b1111;
                w_wdata   = 32'h0000_0000;
            end
        endcase
    end

    load_data_aligner u_load_data_aligner (
        .i_word      (CACHE_RESP_RDATA),
        .i_offset    (r_offset),
        .i_load_type (r_load_type),
        .o_data      (w_aligned)
    );

    // Completion in the final allowed cycle takes priority over the timeout
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count + 1'b1;
        w_timeout_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MEM_VALID && w_has_access) begin
                    w_state_next = w_fault ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (CACHE_REQ_READY) begin
                    w_state_next = r_req_write ? ST_DONE : ST_WAIT;
                end else if (w_count_next == c_TIMEOUT_VAL) begin
                    w_state_next   = ST_DONE;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_WAIT: begin
                if (CACHE_RESP_VALID) begin
                    w_state_next = ST_DONE;
                end else if (w_count_next == c_TIMEOUT_VAL) begin
                    w_state_next   = ST_DONE;
                    w_timeout_fire = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count       <= '0;
            r_req_write   <= 1'b0;
            r_req_addr    <= 32'h0000_0000;
            r_byte_en     <= 4'b0000;
            r_wdata       <= 32'h0000_0000;
            r_offset      <= 2'b00;
            r_load_type   <= c_RD_NONE;
            r_rd_latched  <= 5'd0;
            r_load_data   <= 32'h0000_0000;
            r_load_rd     <= 5'd0;
            r_load_done   <= 1'b0;
            r_is_fault    <= 1'b0;
            r_fault_cause <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (MEM_VALID && w_has_access) begin
                        if (w_fault) begin
                            r_is_fault    <= 1'b1;
                            r_fault_cause <= w_illegal ? c_FAULT_ILLEGAL : c_FAULT_MISALIGNED;
                        end else begin
                            r_count      <= '0;
                            r_req_write  <= (DATA_CACHE_WRITE != c_WR_NONE);
                            r_req_addr   <= {ADDRESS[31:2], 2'b00};
                            r_byte_en    <= w_byte_en;
                            r_wdata      <= w_wdata;
                            r_offset     <= ADDRESS[1:0];
                            r_load_type  <= DATA_CACHE_READ;
                            r_rd_latched <= RD_ADDRESS;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    r_count <= w_count_next;
                    if (w_timeout_fire) begin
                        r_is_fault    <= 1'b1;
                        r_fault_cause <= c_FAULT_TIMEOUT;
                    end else if (r_state == ST_WAIT && CACHE_RESP_VALID) begin
                        r_load_data <= w_aligned;
                        r_load_rd   <= r_rd_latched;
                        r_load_done <= 1'b1;
                    end
                end
                default: begin
                    r_load_done <= 1'b0;
                    r_is_fault  <= 1'b0;
                end
            endcase
        end
    end

    // Reset also masks the combinational stall so every output reads 0
    assign STALL             = RST_N &&
                               ((r_state == ST_IDLE && MEM_VALID && w_has_access) ||
                                r_state == ST_REQ || r_state == ST_WAIT);
    assign CACHE_REQ_VALID   = (r_state == ST_REQ);
    assign CACHE_REQ_WRITE   = r_req_write;
    assign CACHE_REQ_ADDRESS = r_req_addr;
    assign CACHE_REQ_BYTE_EN = r_byte_en;
    assign CACHE_REQ_WDATA   = r_wdata;
    assign LOAD_VALID        = (r_state == ST_DONE) && r_load_done;
    assign LOAD_DATA         = r_load_data;
    assign LOAD_RD_ADDRESS   = r_load_rd;
    assign ACCESS_FAULT      = (r_state == ST_DONE) && r_is_fault;
    assign FAULT_CAUSE       = r_fault_cause;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_sequencer
// Description : Directed self-checking bench for mem_access_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mem_valid, mem_valid_t;
    logic [2:0]  rd_code;
    logic [1:0]  wr_code;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        ready, ready_t;
    logic        resp_valid, resp_valid_t;
    logic [31:0] rdata;

    logic        stall, req_valid, req_write, load_valid, fault;
    logic [31:0] req_addr, req_wdata, load_data;
    logic [3:0]  req_be;
    logic [4:0]  load_rd;
    logic [1:0]  cause;

    logic        t_stall, t_req_valid, t_req_write, t_load_valid, t_fault;
    logic [31:0] t_req_addr, t_req_wdata, t_load_data;
    logic [3:0]  t_req_be;
    logic [4:0]  t_load_rd;
    logic [1:0]  t_cause;

    int checks   = 0;
    int failures = 0;

    mem_access_sequencer dut (
        .CLK               (clk),
        .RST_N             (rst_n),
        .MEM_VALID         (mem_valid),
        .DATA_CACHE_READ   (rd_code),
        .DATA_CACHE_WRITE  (wr_code),
        .ADDRESS           (addr),
        .STORE_DATA        (store_data),
        .RD_ADDRESS        (rd_addr),
        .STALL             (stall),
        .CACHE_REQ_VALID   (req_valid),
        .CACHE_REQ_READY   (ready),
        .CACHE_REQ_WRITE   (req_write),
        .CACHE_REQ_ADDRESS (req_addr),
        .CACHE_REQ_BYTE_EN (req_be),
        .CACHE_REQ_WDATA   (req_wdata),
        .CACHE_RESP_VALID  (resp_valid),
        .CACHE_RESP_RDATA  (rdata),
        .LOAD_VALID        (load_valid),
        .LOAD_DATA         (load_data),
        .LOAD_RD_ADDRESS   (load_rd),
        .ACCESS_FAULT      (fault),
        .FAULT_CAUSE       (cause)
    );

    mem_access_sequencer #(.TIMEOUT_CYCLES(4)) dut_to (
        .CLK               (clk),
        .RST_N             (rst_n),
        .MEM_VALID         (mem_valid_t),
        .DATA_CACHE_READ   (rd_code),
        .DATA_CACHE_WRITE  (wr_code),
        .ADDRESS           (addr),
        .STORE_DATA        (store_data),
        .RD_ADDRESS        (rd_addr),
        .STALL             (t_stall),
        .CACHE_REQ_VALID   (t_req_valid),
        .CACHE_REQ_READY   (ready_t),
        .CACHE_REQ_WRITE   (t_req_write),
        .CACHE_REQ_ADDRESS (t_req_addr),
        .CACHE_REQ_BYTE_EN (t_req_be),
        .CACHE_REQ_WDATA   (t_req_wdata),
        .CACHE_RESP_VALID  (resp_valid_t),
        .CACHE_RESP_RDATA  (rdata),
        .LOAD_VALID        (t_load_valid),
        .LOAD_DATA         (t_load_data),
        .LOAD_RD_ADDRESS   (t_load_rd),
        .ACCESS_FAULT      (t_fault),
        .FAULT_CAUSE       (t_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Load with the response one cycle after the accept
    task automatic do_load(input string tag, input logic [2:0] code, input logic [31:0] a,
                           input logic [31:0] word, input logic [4:0] dst,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        tick;
        mem_valid = 1'b1; rd_code = code; wr_code = 2'b00; addr = a; rd_addr = dst; ready = 1'b1;
        #2 chk({tag, "_stall_c1"}, stall, 1);
        tick;
        #2 chk({tag, "_req_valid"}, req_valid, 1);
        chk({tag, "_req_addr"}, req_addr, exp_addr);
        chk({tag, "_req_be"}, req_be, 4'hF);
        chk({tag, "_req_write"}, req_write, 0);
        tick;
        resp_valid = 1'b1; rdata = word;
        #2 chk({tag, "_stall_wait"}, stall, 1);
        chk({tag, "_lv_wait"}, load_valid, 0);
        tick;
        mem_valid = 1'b0; resp_valid = 1'b0; rdata = 32'h0;
        #2 chk({tag, "_load_valid"}, load_valid, 1);
        chk({tag, "_load_data"}, load_data, exp_data);
        chk({tag, "_load_rd"}, load_rd, dst);
        chk({tag, "_stall_done"}, stall, 0);
        tick;
        #2 chk({tag, "_lv_drop"}, load_valid, 0);
        chk({tag, "_data_hold"}, load_data, exp_data);
    endtask

    task automatic do_fault(input string tag, input logic [2:0] rcode, input logic [1:0] wcode,
                            input logic [31:0] a, input logic [1:0] exp_cause);
        tick;
        mem_valid = 1'b1; rd_code = rcode; wr_code = wcode; addr = a; ready = 1'b1;
        #2 chk({tag, "_stall_c1"}, stall, 1);
        chk({tag, "_no_req_c1"}, req_valid, 0);
        tick;
        mem_valid = 1'b0;
        #2 chk({tag, "_fault"}, fault, 1);
        chk({tag, "_cause"}, cause, exp_cause);
        chk({tag, "_no_req_c2"}, req_valid, 0);
        chk({tag, "_stall_done"}, stall, 0);
        tick;
        #2 chk({tag, "_fault_drop"}, fault, 0);
    endtask

    initial begin
        rst_n = 1'b0; mem_valid = 1'b0; mem_valid_t = 1'b0;
        rd_code = 3'b000; wr_code = 2'b00; addr = 32'h0; store_data = 32'h0; rd_addr = 5'd0;
        ready = 1'b0; ready_t = 1'b0; resp_valid = 1'b0; resp_valid_t = 1'b0; rdata = 32'h0;

        tick; tick;
        #2 chk("rst_stall", stall, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_cause", cause, 0);
        chk("rst_fault", fault, 0);
        tick;
        rst_n = 1'b1;

        // SB at 0x1002
        tick;
        mem_valid = 1'b1; wr_code = 2'b01; addr = 32'h0000_1002; store_data = 32'h0000_00AB; ready = 1'b1;
        #2 chk("sb_stall_c1", stall, 1);
        chk("sb_no_req_c1", req_valid, 0);
        tick;
        #2 chk("sb_stall_c2", stall, 1);
        chk("sb_req_valid", req_valid, 1);
        chk("sb_req_write", req_write, 1);
        chk("sb_req_addr", req_addr, 32'h0000_1000);
        chk("sb_be", req_be, 4'b0100);
        chk("sb_wdata", req_wdata, 32'hABAB_ABAB);
        tick;
        mem_valid = 1'b0; ready = 1'b0; wr_code = 2'b00;
        #2 chk("sb_stall_done", stall, 0);
        chk("sb_req_drop", req_valid, 0);
        chk("sb_no_lv", load_valid, 0);
        chk("sb_no_fault", fault, 0);

        do_load("lb",  3'b001, 32'h0000_2001, 32'h0000_8000, 5'd7,  32'h0000_2000, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_2001, 32'h0000_8000, 5'd9,  32'h0000_2000, 32'h0000_0080);
        do_load("lh",  3'b010, 32'h0000_2002, 32'h8001_0000, 5'd12, 32'h0000_2000, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_4002, 32'h1234_ABCD, 5'd31, 32'h0000_4000, 32'h0000_1234);
        do_load("lw",  3'b011, 32'h0000_4008, 32'hCAFE_F00D, 5'd1,  32'h0000_4008, 32'hCAFE_F00D);

        // SH with five cycles of backpressure; inputs change while held
        tick;
        mem_valid = 1'b1; rd_code = 3'b000; wr_code = 2'b10; addr = 32'h0000_1006;
        store_data = 32'h1234_CDEF; ready = 1'b0;
        tick;
        addr = 32'hFFFF_FFFF; store_data = 32'h0; wr_code = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #2 chk("bp_req_valid", req_valid, 1);
            chk("bp_stall", stall, 1);
            chk("bp_addr", req_addr, 32'h0000_1004);
            chk("bp_be", req_be, 4'b1100);
            chk("bp_wdata", req_wdata, 32'hCDEF_CDEF);
            chk("bp_write", req_write, 1);
            tick;
        end
        ready = 1'b1;
        #2 chk("bp_req_valid_last", req_valid, 1);
        tick;
        mem_valid = 1'b0; ready = 1'b0; wr_code = 2'b00;
        #2 chk("bp_done_stall", stall, 0);
        chk("bp_done_req", req_valid, 0);

        do_fault("mis_lw",  3'b011, 2'b00, 32'h0000_3002, 2'b00);
        do_fault("mis_sh",  3'b000, 2'b10, 32'h0000_3001, 2'b00);
        do_fault("ill_110", 3'b110, 2'b00, 32'h0000_3000, 2'b01);
        do_fault("ill_both", 3'b011, 2'b11, 32'h0000_3000, 2'b01);

        // Timeout instance: load accepted, no response in time
        tick;
        mem_valid_t = 1'b1; rd_code = 3'b011; wr_code = 2'b00; addr = 32'h0000_4000; ready_t = 1'b1;
        #2 chk("to_stall_c1", t_stall, 1);
        tick;
        #2 chk("to_req_valid", t_req_valid, 1);
        ready_t = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            #2 chk("to_wait_stall", t_stall, 1);
            chk("to_wait_no_fault", t_fault, 0);
        end
        tick;
        mem_valid_t = 1'b0;
        #2 chk("to_fault", t_fault, 1);
        chk("to_cause", t_cause, 2'b10);
        chk("to_no_lv", t_load_valid, 0);
        chk("to_req_drop", t_req_valid, 0);
        chk("to_stall_done", t_stall, 0);
        tick;
        resp_valid_t = 1'b1; rdata = 32'h1111_1111;
        #2 chk("late_no_lv", t_load_valid, 0);
        chk("late_no_stall", t_stall, 0);
        tick;
        #2 chk("late_no_lv2", t_load_valid, 0);
        chk("late_no_fault", t_fault, 0);
        resp_valid_t = 1'b0; rdata = 32'h0;

        // Reset while waiting for a load response
        tick;
        mem_valid = 1'b1; rd_code = 3'b011; wr_code = 2'b00; addr = 32'h0000_5000; rd_addr = 5'd3; ready = 1'b1;
        tick;
        tick;
        #2 chk("rw_stall_wait", stall, 1);
        rst_n = 1'b0;
        #1 chk("rw_stall", stall, 0);
        chk("rw_req_valid", req_valid, 0);
        chk("rw_req_write", req_write, 0);
        chk("rw_req_addr", req_addr, 0);
        chk("rw_be", req_be, 0);
        chk("rw_wdata", req_wdata, 0);
        chk("rw_load_valid", load_valid, 0);
        chk("rw_load_data", load_data, 0);
        chk("rw_load_rd", load_rd, 0);
        chk("rw_fault", fault, 0);
        chk("rw_cause", cause, 0);
        chk("rw_to_cause", t_cause, 0);
        mem_valid = 1'b0; rd_code = 3'b000; ready = 1'b0;
        tick; tick;
        rst_n = 1'b1;

        // SW after reset release
        tick;
        mem_valid = 1'b1; wr_code = 2'b11; addr = 32'h0000_6004; store_data = 32'hDEAD_BEEF; ready = 1'b1;
        #2 chk("sw_stall_c1", stall, 1);
        tick;
        #2 chk("sw_req_valid", req_valid, 1);
        chk("sw_req_addr", req_addr, 32'h0000_6004);
        chk("sw_be", req_be, 4'hF);
        chk("sw_wdata", req_wdata, 32'hDEAD_BEEF);
        chk("sw_write", req_write, 1);
        tick;
        mem_valid = 1'b0; ready = 1'b0; wr_code = 2'b00;
        #2 chk("sw_stall_done", stall, 0);
        chk("sw_req_drop", req_valid, 0);
        chk("sw_no_fault", fault, 0);
        tick;
        #2 chk("sw_idle_stall", stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
